// File: rtl/instr_fetch.sv
// Instruction fetch: PC plus loadable ROM, one registered instruction per unstalled cycle, zero-bubble redirects.
// Latency: inputs sampled at an edge select the instr/pc shown after it; stall freezes all fetch state.
module instr_fetch #(
  parameter int              ROM_DEPTH = 16,
  parameter int              ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [31:0]       rom [ROM_DEPTH];
  logic [31:0]       instr_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              valid_nxt;
  logic              halted_nxt;

  logic [17:0]       br_sum;
  logic [ADDR_W:0]   seq_sum;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_oor;

  // ROM is never reset; the read path sees the pre-edge word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (load_en) rom[load_addr] <= load_data;
  end

  // Branch target kept at 18 bits signed so negative or overflowing targets are detected, never wrapped.
  always_comb begin
    seq_sum = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
    br_sum  = {{(18-ADDR_W){1'b0}}, pc} + 18'd1 + {{2{branch_offset[15]}}, branch_offset};
    tgt     = seq_sum[ADDR_W-1:0];
    tgt_oor = seq_sum[ADDR_W];
    if (jump) begin
      tgt     = jump_target[ADDR_W-1:0];
      tgt_oor = |jump_target[25:ADDR_W];
    end else if (branch_taken) begin
      tgt     = br_sum[ADDR_W-1:0];
      tgt_oor = |br_sum[17:ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!stall) state_nxt = RUN;
      RUN:     if (!stall && tgt_oor) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_nxt  = instr;
    pc_nxt     = pc;
    valid_nxt  = instr_valid;
    halted_nxt = halted;
    case (state)
      IDLE: begin
        if (!stall) begin
          instr_nxt = rom[RESET_PC];
          valid_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (tgt_oor) begin
            instr_nxt  = 32'h0;
            valid_nxt  = 1'b0;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt    = tgt;
            instr_nxt = rom[tgt];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= 32'h0;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr       <= instr_nxt;
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
      halted      <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branch/jump redirect, stall, halt, reset and ROM reload.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = 4'h0;
  logic [31:0] load_data = 32'h0;
  logic [31:0] instr;
  logic [3:0]  pc;
  logic        instr_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ROM_DEPTH(16), .ADDR_W(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr(instr), .pc(pc), .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // One rising edge; outputs are then sampled and inputs changed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
    jump = 1'b0; jump_target = 26'h0; load_en = 1'b0;
  endtask

  // Reset pulse then run until the given PC is the one being shown.
  task automatic restart_at(input int n);
    clear_ctrl();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (n + 1) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = 32'h100 + i;
      tick();
    end
    load_en = 1'b0;
    checks++;
    if (instr !== 32'h0 || pc !== 4'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: instr=%h pc=%0d valid=%b halted=%b, want 0/0/0/0", instr, pc, instr_valid, halted);
    end
    // Stall in IDLE must keep the stage empty.
    reset = 1'b0; stall = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL idle_stall: valid=%b instr=%h, want 0/0", instr_valid, instr);
    end
    stall = 1'b0;
  endtask

  task automatic test_sequential();
    tick();
    checks++;
    if (pc !== 4'd0 || instr !== 32'h100 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch: pc=%0d instr=%h valid=%b, want 0/100/1", pc, instr, instr_valid);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (pc !== 4'(i) || instr !== 32'h100 + i || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_fetch_%0d: pc=%0d instr=%h valid=%b, want %0d/%h/1", i, pc, instr, instr_valid, i, 32'h100 + i);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'd15 || instr !== 32'h0) begin
      errors++;
      $display("FAIL seq_end_halt: halted=%b valid=%b pc=%0d instr=%h, want 1/0/15/0", halted, instr_valid, pc, instr);
    end
    // HALT ignores redirects and stall.
    jump = 1'b1; jump_target = 26'd2; branch_taken = 1'b1; branch_offset = 16'hFFF0;
    tick(); tick();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'd15) begin
      errors++;
      $display("FAIL halt_hold: halted=%b valid=%b pc=%0d, want 1/0/15", halted, instr_valid, pc);
    end
    clear_ctrl();
  endtask

  task automatic test_halt_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0 || pc !== 4'd0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b valid=%b pc=%0d instr=%h, want 0/0/0/0", halted, instr_valid, pc, instr);
    end
    tick();
    checks++;
    if (pc !== 4'd0 || instr_valid !== 1'b1 || instr !== 32'h100) begin
      errors++;
      $display("FAIL halt_reset_refetch: pc=%0d valid=%b instr=%h, want 0/1/100", pc, instr_valid, instr);
    end
  endtask

  task automatic test_branch();
    restart_at(5);
    branch_taken = 1'b1; branch_offset = 16'hFFFA;
    tick();
    checks++;
    if (pc !== 4'd0 || instr !== 32'h100 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_back: pc=%0d instr=%h valid=%b, want 0/100/1", pc, instr, instr_valid);
    end
    restart_at(5);
    branch_taken = 1'b1; branch_offset = 16'h0009;
    tick();
    checks++;
    if (pc !== 4'd15 || instr !== 32'h10F || halted !== 1'b0) begin
      errors++;
      $display("FAIL branch_fwd_edge: pc=%0d instr=%h halted=%b, want 15/10f/0", pc, instr, halted);
    end
    restart_at(5);
    branch_taken = 1'b1; branch_offset = 16'h000A;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd5 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_over: halted=%b pc=%0d valid=%b, want 1/5/0", halted, pc, instr_valid);
    end
    restart_at(5);
    branch_taken = 1'b1; branch_offset = 16'hFFF9;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd5 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL branch_neg: halted=%b pc=%0d valid=%b instr=%h, want 1/5/0/0", halted, pc, instr_valid, instr);
    end
    clear_ctrl();
  endtask

  task automatic test_jump();
    restart_at(3);
    jump = 1'b1; jump_target = 26'd12; branch_taken = 1'b1; branch_offset = 16'h0002;
    tick();
    checks++;
    if (pc !== 4'd12 || instr !== 32'h10C) begin
      errors++;
      $display("FAIL jump_wins: pc=%0d instr=%h, want 12/10c", pc, instr);
    end
    restart_at(3);
    jump = 1'b1; jump_target = 26'h10; branch_taken = 1'b1; branch_offset = 16'h0002;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd3 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_oor: halted=%b pc=%0d valid=%b, want 1/3/0", halted, pc, instr_valid);
    end
    clear_ctrl();
  endtask

  task automatic test_stall();
    restart_at(2);
    stall = 1'b1; jump = 1'b1; jump_target = 26'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 4'd2 || instr !== 32'h102 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%0d instr=%h valid=%b, want 2/102/1", i, pc, instr, instr_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 4'd9 || instr !== 32'h109) begin
      errors++;
      $display("FAIL stall_release_jump: pc=%0d instr=%h, want 9/109", pc, instr);
    end
    clear_ctrl();
  endtask

  task automatic test_rom_write();
    restart_at(6);
    load_en = 1'b1; load_addr = 4'd7; load_data = 32'hDEAD;
    tick();
    load_en = 1'b0;
    checks++;
    if (pc !== 4'd7 || instr !== 32'h107) begin
      errors++;
      $display("FAIL rbw_old_word: pc=%0d instr=%h, want 7/107", pc, instr);
    end
    branch_taken = 1'b1; branch_offset = 16'hFFFF;
    tick();
    checks++;
    if (pc !== 4'd7 || instr !== 32'hDEAD) begin
      errors++;
      $display("FAIL rbw_new_word: pc=%0d instr=%h, want 7/dead", pc, instr);
    end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_halt_reset();
    test_branch();
    test_jump();
    test_halt_reset();
    test_stall();
    test_rom_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
